// File: rtl/result_packer.sv
// Packs a snapshot of THREAD_NUMBER 16-bit result lanes into 32-bit words and
// streams them, lane pair by lane pair, into a send FIFO that can backpressure.
module result_packer #(
  parameter int THREAD_NUMBER = 256,
  parameter int LANE_WIDTH    = 16
) (
  input  logic                                bus_clk,
  input  logic                                rst_n,
  input  logic                                clear,
  input  logic [THREAD_NUMBER*LANE_WIDTH-1:0] res_data,
  input  logic                                res_valid,
  output logic                                wr_en,
  output logic [2*LANE_WIDTH-1:0]             wr_data,
  input  logic                                wr_full,
  output logic                                busy,
  output logic                                done,
  output logic [15:0]                         word_count
);

  // state | meaning
  // IDLE  | waiting for res_valid to capture a snapshot
  // SEND  | writing word k = {lane 2k+1, lane 2k} while the FIFO has room
  // DONE  | one-cycle completion pulse
  // REARM | waiting for res_valid to drop so one valid level yields one transfer
  typedef enum logic [1:0] {IDLE, SEND, DONE, REARM} state_e;

  localparam int WORDS  = THREAD_NUMBER / 2;
  localparam int WORD_W = 2 * LANE_WIDTH;
  localparam int K_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(WORDS - 1);

  state_e             state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [15:0]        word_count_q, word_count_d;
  logic [WORD_W-1:0]  snap_q [WORDS];
  logic [WORD_W-1:0]  snap_d [WORDS];
  logic               accept;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    word_count_d = word_count_q;
    snap_d       = snap_q;
    accept       = (state_q == SEND) && !wr_full && !clear;

    // clear outranks both a fresh capture and a write acceptance
    if (clear) begin
      state_d      = IDLE;
      k_d          = '0;
      word_count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (res_valid) begin
            for (int i = 0; i < WORDS; i++) begin
              snap_d[i] = res_data[WORD_W*i +: WORD_W];
            end
            k_d          = '0;
            word_count_d = '0;
            state_d      = SEND;
          end
        end
        SEND: begin
          if (accept) begin
            word_count_d = word_count_q + 16'd1;
            // k parks on the last index rather than wrapping
            if (k_q == K_LAST) state_d = DONE;
            else               k_d     = k_q + K_W'(1);
          end
        end
        DONE:  state_d = REARM;
        REARM: if (!res_valid) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge bus_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      k_q          <= '0;
      word_count_q <= '0;
      for (int i = 0; i < WORDS; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      word_count_q <= word_count_d;
      snap_q       <= snap_d;
    end
  end

  assign wr_en      = accept;
  assign wr_data    = (state_q == SEND) ? snap_q[k_q] : '0;
  assign busy       = (state_q == SEND) || (state_q == DONE);
  assign done       = (state_q == DONE);
  assign word_count = word_count_q;

endmodule
